// File: rtl/digit_entry.sv
// Keypad digit-entry register: shifts qualified key strobes in as packed 4-bit digits,
// with backspace, clear, digit count/full tracking and optional overflow scrolling.
// Latency: out/count/accept/reject update on the edge that samples the strobe; no backpressure.
// Ports: clk, rst (sync, active-high), en (key strobe), in (5-bit keycode), bksp, clr,
//        out (packed digits, newest in [3:0]), count, full (decoded), accept/reject (1-cycle pulses).
module digit_entry #(
    parameter int NDIGITS = 8,
    parameter int RADIX   = 10,
    parameter int EDGE    = 1,
    parameter int OVF     = 0,
    localparam int CW     = $clog2(NDIGITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4:0]             in,
    input  logic                   bksp,
    input  logic                   clr,
    output logic [4*NDIGITS-1:0]   out,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   accept,
    output logic                   reject
);

    localparam logic [CW-1:0] CMAX = CW'(NDIGITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic                 en_q;
    logic                 act;
    logic                 is_digit;
    logic [4*NDIGITS+3:0] shift_wide;
    logic [4*NDIGITS-1:0] out_n;
    logic [CW-1:0]        count_n;
    logic                 accept_n;
    logic                 reject_n;

    // After reset en_q is 0, so an en already high when rst drops is taken as a rising edge.
    assign act      = (EDGE != 0) ? (en & ~en_q) : en;
    // Any keycode with in[4] set is >= 16 and therefore never a digit.
    assign is_digit = (in < 5'(RADIX));
    // Widened concatenation keeps the shift legal for NDIGITS=1; the top digit falls off.
    assign shift_wide = {out, in[3:0]};
    assign full       = (count == CMAX);

    always_comb begin
        out_n    = out;
        count_n  = count;
        accept_n = 1'b0;
        reject_n = 1'b0;
        if (clr) begin
            out_n   = '0;
            count_n = '0;
        end else if (act) begin
            if (bksp) begin
                if (count != '0) begin
                    out_n    = out >> 4;
                    count_n  = count - ONE;
                    accept_n = 1'b1;
                end else begin
                    reject_n = 1'b1;
                end
            end else if (!is_digit) begin
                reject_n = 1'b1;
            end else if (!full) begin
                out_n    = shift_wide[4*NDIGITS-1:0];
                count_n  = count + ONE;
                accept_n = 1'b1;
            end else if (OVF != 0) begin
                // Scroll: count stays pinned at NDIGITS.
                out_n    = shift_wide[4*NDIGITS-1:0];
                accept_n = 1'b1;
            end else begin
                reject_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            out    <= '0;
            count  <= '0;
            accept <= 1'b0;
            reject <= 1'b0;
        end else begin
            en_q   <= en;
            out    <= out_n;
            count  <= count_n;
            accept <= accept_n;
            reject <= reject_n;
        end
    end

endmodule

// File: tb/tb_digit_entry.sv
module tb_digit_entry;

    logic       clk = 1'b0;
    logic       rst, en, bksp, clr;
    logic [4:0] in;

    // Default config: 8 digits, radix 10, edge-qualified, reject when full.
    logic [31:0] out_a;
    logic [3:0]  count_a;
    logic        full_a, acc_a, rej_a;
    // Level-qualified variant.
    logic [31:0] out_b;
    logic [3:0]  count_b;
    logic        full_b, acc_b, rej_b;
    // 4 digits with overflow scrolling.
    logic [15:0] out_c;
    logic [2:0]  count_c;
    logic        full_c, acc_c, rej_c;

    int n_total = 0;
    int n_bad   = 0;
    int acc_cnt_a, acc_cnt_b, acc_cnt_c;
    logic last_acc_a, last_rej_a, last_acc_c, last_rej_c;

    always #5 clk = ~clk;

    digit_entry #(.NDIGITS(8), .RADIX(10), .EDGE(1), .OVF(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .in(in), .bksp(bksp), .clr(clr),
        .out(out_a), .count(count_a), .full(full_a), .accept(acc_a), .reject(rej_a));

    digit_entry #(.NDIGITS(8), .RADIX(10), .EDGE(0), .OVF(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in(in), .bksp(bksp), .clr(clr),
        .out(out_b), .count(count_b), .full(full_b), .accept(acc_b), .reject(rej_b));

    digit_entry #(.NDIGITS(4), .RADIX(10), .EDGE(1), .OVF(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .in(in), .bksp(bksp), .clr(clr),
        .out(out_c), .count(count_c), .full(full_c), .accept(acc_c), .reject(rej_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle followed by one idle cycle; records the pulses seen after the strobe edge.
    task automatic press(input logic [4:0] k);
        in = k;
        en = 1'b1;
        tick();
        last_acc_a = acc_a; last_rej_a = rej_a;
        last_acc_c = acc_c; last_rej_c = rej_c;
        en = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in = 5'd5; bksp = 1'b0; clr = 1'b0;
        last_acc_a = 0; last_rej_a = 0; last_acc_c = 0; last_rej_c = 0;

        // 1: reset holds everything at zero while en toggles.
        for (int i = 0; i < 10; i++) begin
            en = ~en;
            tick();
            chk("rst_out", out_a, 32'h0);
            chk("rst_count", {28'h0, count_a}, 32'h0);
            chk("rst_pulses", {30'h0, acc_a, rej_a}, 32'h0);
            chk("rst_c_out", {16'h0, out_c}, 32'h0);
        end
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("idle_full", {31'h0, full_a}, 32'h0);

        // 2: fill eight digits 9..2.
        acc_cnt_a = 0;
        for (int d = 9; d >= 2; d--) begin
            press(5'(d));
            if (last_acc_a && !last_rej_a) acc_cnt_a++;
        end
        chk("fill_out", out_a, 32'h98765432);
        chk("fill_count", {28'h0, count_a}, 32'd8);
        chk("fill_full", {31'h0, full_a}, 32'h1);
        chk("fill_accepts", 32'(acc_cnt_a), 32'd8);
        press(5'd1);
        chk("full_rej", {30'h0, last_acc_a, last_rej_a}, 32'h1);
        chk("full_hold", out_a, 32'h98765432);
        do_clr();
        tick();
        chk("clr_out", out_a, 32'h0);
        chk("clr_full", {31'h0, full_a}, 32'h0);
        press(5'd10);
        chk("radix_rej", {30'h0, last_acc_a, last_rej_a}, 32'h1);
        chk("radix_out", out_a, 32'h0);
        press(5'd17);
        chk("in4_rej", {30'h0, last_acc_a, last_rej_a}, 32'h1);
        chk("in4_count", {28'h0, count_a}, 32'h0);

        // 3: en held six cycles: one action with EDGE=1, six with EDGE=0.
        do_clr();
        acc_cnt_a = 0; acc_cnt_b = 0;
        in = 5'd3;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acc_a) acc_cnt_a++;
            if (acc_b) acc_cnt_b++;
        end
        en = 1'b0;
        tick();
        chk("hold_e1_out", out_a, 32'h3);
        chk("hold_e1_count", {28'h0, count_a}, 32'd1);
        chk("hold_e1_acc", 32'(acc_cnt_a), 32'd1);
        chk("hold_e0_out", out_b, 32'h333333);
        chk("hold_e0_count", {28'h0, count_b}, 32'd6);
        chk("hold_e0_acc", 32'(acc_cnt_b), 32'd6);

        // 4: backspace.
        do_clr();
        press(5'd1); press(5'd2); press(5'd3);
        chk("bs_pre", out_a, 32'h123);
        bksp = 1'b1;
        press(5'd9);
        chk("bs1_out", out_a, 32'h12);
        chk("bs1_count", {28'h0, count_a}, 32'd2);
        chk("bs1_acc", {30'h0, last_acc_a, last_rej_a}, 32'h2);
        press(5'd9);
        press(5'd9);
        chk("bs3_acc", {30'h0, last_acc_a, last_rej_a}, 32'h2);
        press(5'd9);
        chk("bs4_rej", {30'h0, last_acc_a, last_rej_a}, 32'h1);
        chk("bs4_out", out_a, 32'h0);
        chk("bs4_count", {28'h0, count_a}, 32'h0);
        bksp = 1'b0;

        // 5: clr wins over a simultaneous rising strobe, and en held high afterwards is not a new edge.
        do_clr();
        press(5'd4); press(5'd5);
        chk("pre_clr", out_a, 32'h45);
        in = 5'd7; en = 1'b1; clr = 1'b1;
        tick();
        chk("clr_act_out", out_a, 32'h0);
        chk("clr_act_count", {28'h0, count_a}, 32'h0);
        chk("clr_act_pulses", {30'h0, acc_a, rej_a}, 32'h0);
        clr = 1'b0;
        tick();
        chk("after_clr_out", out_a, 32'h0);
        chk("after_clr_pulses", {30'h0, acc_a, rej_a}, 32'h0);
        en = 1'b0;
        tick();

        // 6: overflow scrolling with four digits, then reset mid-entry.
        do_clr();
        acc_cnt_c = 0;
        for (int d = 1; d <= 5; d++) begin
            press(5'(d));
            if (last_acc_c && !last_rej_c) acc_cnt_c++;
        end
        chk("ovf_out", {16'h0, out_c}, 32'h2345);
        chk("ovf_count", {29'h0, count_c}, 32'd4);
        chk("ovf_full", {31'h0, full_c}, 32'h1);
        chk("ovf_accepts", 32'(acc_cnt_c), 32'd5);
        press(5'd6);
        chk("ovf_scroll", {16'h0, out_c}, 32'h3456);
        in = 5'd6; en = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst_out", {16'h0, out_c}, 32'h0);
        chk("mid_rst_count", {29'h0, count_c}, 32'h0);
        chk("mid_rst_pulses", {30'h0, acc_c, rej_c}, 32'h0);
        chk("mid_rst_a_out", out_a, 32'h0);
        rst = 1'b0;
        tick();
        // en still high out of reset is treated as a fresh rising edge.
        chk("post_rst_acc", {30'h0, acc_c, rej_c}, 32'h2);
        chk("post_rst_out", {16'h0, out_c}, 32'h6);
        chk("post_rst_count", {29'h0, count_c}, 32'd1);
        en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
